// File: rtl/const_reg_arbiter.sv
// Round-robin write arbiter in front of a constant-initialised shared register.
// Tracks whether the register still holds a constant (reset or clear) value.
module const_reg_arbiter #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VAL   = 8'h5A,
   parameter int unsigned      HOLD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   input  logic             clear,
   output logic             grant_a,
   output logic             grant_b,
   output logic             busy,
   output logic [WIDTH-1:0] reg_q,
   output logic             reg_is_const,
   output logic [7:0]       update_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam bit         HOLD_ZERO = (HOLD_CYCLES == 0);
   localparam logic [3:0] HOLD_LOAD = HOLD_ZERO ? 4'd0 : 4'(HOLD_CYCLES - 1);

   state_t           state_r, state_s;
   logic             sel_b_r, sel_b_s;
   logic             last_b_r;
   logic             pending_clear_r;
   logic             do_clear_s;
   logic [3:0]       hold_cnt_r;
   logic [WIDTH-1:0] reg_q_r;
   logic             reg_is_const_r;
   logic [7:0]       update_count_r;

   // State register and latched write target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         sel_b_r <= 1'b0;
      end else begin
         state_r <= state_s;
         sel_b_r <= sel_b_s;
      end
   end

   // Next-state logic: a clear (new or pending) outranks any request in IDLE
   always_comb begin
      state_s    = state_r;
      sel_b_s    = sel_b_r;
      do_clear_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (clear || pending_clear_r) begin
               do_clear_s = 1'b1;
               state_s    = HOLD_ZERO ? ST_IDLE : ST_HOLD;
            end else if (req_a && req_b) begin
               state_s = ST_WRITE;
               sel_b_s = ~last_b_r;
            end else if (req_a) begin
               state_s = ST_WRITE;
               sel_b_s = 1'b0;
            end else if (req_b) begin
               state_s = ST_WRITE;
               sel_b_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_s = HOLD_ZERO ? ST_IDLE : ST_HOLD;
         end
         ST_HOLD: begin
            if (hold_cnt_r == 4'd0) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      busy    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_WRITE: begin
            grant_a = ~sel_b_r;
            grant_b = sel_b_r;
            busy    = 1'b1;
         end
         ST_HOLD: begin
            busy = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Lockout down-counter, loaded on entry to HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= 4'd0;
      end else if ((state_s == ST_HOLD) && (state_r != ST_HOLD)) begin
         hold_cnt_r <= HOLD_LOAD;
      end else if ((state_r == ST_HOLD) && (hold_cnt_r != 4'd0)) begin
         hold_cnt_r <= hold_cnt_r - 4'd1;
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end

   // Register contents, const flag, write counter and arbitration history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_q_r         <= RESET_VAL;
         reg_is_const_r  <= 1'b1;
         update_count_r  <= 8'd0;
         last_b_r        <= 1'b1;
         pending_clear_r <= 1'b0;
      end else if (do_clear_s) begin
         reg_q_r         <= {WIDTH{1'b0}};
         reg_is_const_r  <= 1'b1;
         pending_clear_r <= 1'b0;
      end else if (state_r == ST_WRITE) begin
         reg_q_r         <= sel_b_r ? data_b : data_a;
         reg_is_const_r  <= 1'b0;
         update_count_r  <= (update_count_r == 8'hFF) ? 8'hFF : update_count_r + 8'd1;
         last_b_r        <= sel_b_r;
         pending_clear_r <= pending_clear_r | clear;
      end else if (state_r == ST_HOLD) begin
         pending_clear_r <= pending_clear_r | clear;
      end else begin
         pending_clear_r <= pending_clear_r;
      end
   end

   assign reg_q        = reg_q_r;
   assign reg_is_const = reg_is_const_r;
   assign update_count = update_count_r;

endmodule

// File: tb/tb_const_reg_arbiter.sv
// Self-checking bench for const_reg_arbiter: directed vector table, async reset
// during WRITE, randomized run against a cycle model, and count saturation.
module tb_const_reg_arbiter;

   localparam int H = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ra = 1'b0, rb = 1'b0, clr = 1'b0;
   logic [7:0] da = 8'h00, db = 8'h00;
   logic       ga, gb, bsy, kc;
   logic [7:0] q, cnt;

   logic       ra0 = 1'b0, rb0 = 1'b0, clr0 = 1'b0;
   logic [7:0] da0 = 8'h00, db0 = 8'h00;
   logic       ga0, gb0, bsy0, kc0;
   logic [7:0] q0, cnt0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   const_reg_arbiter #(.WIDTH(8), .RESET_VAL(8'h5A), .HOLD_CYCLES(H)) dut (
      .clk(clk), .rst_n(rst_n), .req_a(ra), .data_a(da), .req_b(rb), .data_b(db),
      .clear(clr), .grant_a(ga), .grant_b(gb), .busy(bsy), .reg_q(q),
      .reg_is_const(kc), .update_count(cnt));

   const_reg_arbiter #(.WIDTH(8), .RESET_VAL(8'h5A), .HOLD_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_a(ra0), .data_a(da0), .req_b(rb0), .data_b(db0),
      .clear(clr0), .grant_a(ga0), .grant_b(gb0), .busy(bsy0), .reg_q(q0),
      .reg_is_const(kc0), .update_count(cnt0));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic ra; logic [7:0] da; logic rb; logic [7:0] db; logic clr;
      logic ga; logic gb; logic busy; logic [7:0] q; logic k; logic [7:0] n;
   } vec_t;

   function automatic vec_t mk(input logic r_a, input logic [7:0] d_a, input logic r_b,
                               input logic [7:0] d_b, input logic c, input logic e_ga,
                               input logic e_gb, input logic e_busy, input logic [7:0] e_q,
                               input logic e_k, input logic [7:0] e_n);
      vec_t v;
      v.ra = r_a; v.da = d_a; v.rb = r_b; v.db = d_b; v.clr = c;
      v.ga = e_ga; v.gb = e_gb; v.busy = e_busy; v.q = e_q; v.k = e_k; v.n = e_n;
      return v;
   endfunction

   // Reference model: who writes this cycle, remaining lockout, pending clear
   logic [7:0] m_reg;
   logic       m_const, m_last_b, m_pclr;
   int         m_cnt, m_hold_left, m_wr;

   task automatic model_reset();
      m_reg = 8'h5A; m_const = 1'b1; m_cnt = 0; m_last_b = 1'b1;
      m_pclr = 1'b0; m_hold_left = 0; m_wr = 0;
   endtask

   task automatic model_step();
      if (m_wr != 0) begin
         m_reg = (m_wr == 2) ? db : da;
         m_const = 1'b0;
         if (m_cnt < 255) m_cnt++;
         m_last_b = (m_wr == 2);
         m_wr = 0;
         m_hold_left = H;
         if (clr) m_pclr = 1'b1;
      end else if (m_hold_left > 0) begin
         m_hold_left--;
         if (clr) m_pclr = 1'b1;
      end else if (clr || m_pclr) begin
         m_reg = 8'h00; m_const = 1'b1; m_pclr = 1'b0; m_hold_left = H;
      end else if (ra && rb) begin
         m_wr = m_last_b ? 1 : 2;
      end else if (ra) begin
         m_wr = 1;
      end else if (rb) begin
         m_wr = 2;
      end
   endtask

   vec_t tbl[30];

   initial begin
      tbl[0]  = mk(1, 8'h3C, 0, 8'h00, 0,  0, 0, 0, 8'h5A, 1, 8'd0);
      tbl[1]  = mk(0, 8'h3C, 0, 8'h00, 0,  1, 0, 1, 8'h5A, 1, 8'd0);
      tbl[2]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 8'h3C, 0, 8'd1);
      tbl[3]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h3C, 0, 8'd1);
      tbl[4]  = mk(0, 8'h00, 1, 8'h22, 0,  0, 0, 0, 8'h3C, 0, 8'd1);
      tbl[5]  = mk(0, 8'h00, 1, 8'h22, 0,  0, 0, 1, 8'h00, 1, 8'd1);
      tbl[6]  = mk(0, 8'h00, 1, 8'h22, 0,  0, 0, 1, 8'h00, 1, 8'd1);
      tbl[7]  = mk(0, 8'h00, 1, 8'h22, 0,  0, 0, 0, 8'h00, 1, 8'd1);
      tbl[8]  = mk(1, 8'h11, 1, 8'h22, 0,  0, 1, 1, 8'h00, 1, 8'd1);
      tbl[9]  = mk(1, 8'h11, 1, 8'h22, 0,  0, 0, 1, 8'h22, 0, 8'd2);
      tbl[10] = mk(1, 8'h11, 1, 8'h22, 0,  0, 0, 1, 8'h22, 0, 8'd2);
      tbl[11] = mk(1, 8'h11, 1, 8'h22, 0,  0, 0, 0, 8'h22, 0, 8'd2);
      tbl[12] = mk(0, 8'h11, 1, 8'h22, 0,  1, 0, 1, 8'h22, 0, 8'd2);
      tbl[13] = mk(0, 8'h00, 1, 8'h22, 0,  0, 0, 1, 8'h11, 0, 8'd3);
      tbl[14] = mk(0, 8'h00, 1, 8'h22, 0,  0, 0, 1, 8'h11, 0, 8'd3);
      tbl[15] = mk(0, 8'h00, 1, 8'h33, 0,  0, 0, 0, 8'h11, 0, 8'd3);
      tbl[16] = mk(0, 8'h00, 0, 8'h33, 1,  0, 1, 1, 8'h11, 0, 8'd3);
      tbl[17] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 8'h33, 0, 8'd4);
      tbl[18] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 8'h33, 0, 8'd4);
      tbl[19] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h33, 0, 8'd4);
      tbl[20] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 8'h00, 1, 8'd4);
      tbl[21] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 8'h00, 1, 8'd4);
      tbl[22] = mk(1, 8'h5A, 0, 8'h00, 1,  0, 0, 0, 8'h00, 1, 8'd4);
      tbl[23] = mk(1, 8'h5A, 0, 8'h00, 0,  0, 0, 1, 8'h00, 1, 8'd4);
      tbl[24] = mk(1, 8'h5A, 0, 8'h00, 0,  0, 0, 1, 8'h00, 1, 8'd4);
      tbl[25] = mk(1, 8'h5A, 0, 8'h00, 0,  0, 0, 0, 8'h00, 1, 8'd4);
      tbl[26] = mk(0, 8'h5A, 0, 8'h00, 0,  1, 0, 1, 8'h00, 1, 8'd4);
      tbl[27] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 8'h5A, 0, 8'd5);
      tbl[28] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 8'h5A, 0, 8'd5);
      tbl[29] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h5A, 0, 8'd5);

      // Reset, then directed table: check the row's expectations, then drive its inputs
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      for (int i = 0; i < 30; i++) begin
         chk($sformatf("row%0d_grant_a", i), {31'd0, ga}, {31'd0, tbl[i].ga});
         chk($sformatf("row%0d_grant_b", i), {31'd0, gb}, {31'd0, tbl[i].gb});
         chk($sformatf("row%0d_busy", i), {31'd0, bsy}, {31'd0, tbl[i].busy});
         chk($sformatf("row%0d_reg_q", i), {24'd0, q}, {24'd0, tbl[i].q});
         chk($sformatf("row%0d_is_const", i), {31'd0, kc}, {31'd0, tbl[i].k});
         chk($sformatf("row%0d_count", i), {24'd0, cnt}, {24'd0, tbl[i].n});
         ra = tbl[i].ra; da = tbl[i].da; rb = tbl[i].rb; db = tbl[i].db; clr = tbl[i].clr;
         @(posedge clk) #1;
      end

      // Asynchronous reset in the middle of a WRITE cycle loses the write
      ra = 1'b1; da = 8'hE7;
      @(posedge clk) #1;
      chk("mid_write_grant", {31'd0, ga}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_grant_a", {31'd0, ga}, 32'd0);
      chk("rst_busy", {31'd0, bsy}, 32'd0);
      chk("rst_reg_q", {24'd0, q}, 32'h5A);
      chk("rst_is_const", {31'd0, kc}, 32'd1);
      chk("rst_count", {24'd0, cnt}, 32'd0);
      @(posedge clk) #1;
      ra = 1'b0; da = 8'h00;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      chk("post_rst_reg_q", {24'd0, q}, 32'h5A);
      chk("post_rst_busy", {31'd0, bsy}, 32'd0);

      // Randomized run against the reference model
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         chk("rnd_grant_a", {31'd0, ga}, {31'd0, m_wr == 1});
         chk("rnd_grant_b", {31'd0, gb}, {31'd0, m_wr == 2});
         chk("rnd_busy", {31'd0, bsy}, {31'd0, (m_wr != 0) || (m_hold_left > 0)});
         chk("rnd_reg_q", {24'd0, q}, {24'd0, m_reg});
         chk("rnd_is_const", {31'd0, kc}, {31'd0, m_const});
         chk("rnd_count", {24'd0, cnt}, m_cnt);
         if (m_wr == 1 && $urandom_range(3, 0) != 0) ra = 1'b0;
         else if (!ra && $urandom_range(2, 0) == 0) ra = 1'b1;
         if (m_wr == 2 && $urandom_range(3, 0) != 0) rb = 1'b0;
         else if (!rb && $urandom_range(2, 0) == 0) rb = 1'b1;
         if ($urandom_range(3, 0) == 0) da = 8'($urandom);
         if ($urandom_range(3, 0) == 0) db = 8'($urandom);
         clr = ($urandom_range(9, 0) == 0);
         @(posedge clk);
         model_step();
         #1;
      end
      ra = 1'b0; rb = 1'b0; clr = 1'b0;

      // HOLD_CYCLES=0: grant every second cycle, count saturates at 255
      rb0 = 1'b1; db0 = 8'hA5;
      for (int k = 1; k <= 600; k++) begin
         @(posedge clk) #1;
         chk("sat_grant_b", {31'd0, gb0}, {31'd0, (k % 2) == 1});
         chk("sat_grant_a", {31'd0, ga0}, 32'd0);
         chk("sat_busy", {31'd0, bsy0}, {31'd0, (k % 2) == 1});
         chk("sat_count", {24'd0, cnt0}, ((k / 2) > 255) ? 32'd255 : 32'(k / 2));
      end
      chk("sat_reg_q", {24'd0, q0}, 32'hA5);
      chk("sat_is_const", {31'd0, kc0}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
